register_bank: RTL
==================

# register_bank

General-purpose register file of the 8-bit datapath.
- Write port is fed by the write-back selector output; the write address and enable come from the control unit.
- Two combinational read ports supply the ALU operands. The Ry operand is also fed back to the selector as one of its sources.
- A per-register pending scoreboard stalls the control unit when an operand is still awaiting a multi-cycle bus load.
- Registered Z/N status flags are updated from write-back data.

## Interface
- DATA_W, 8, register and bus data width
- ADDR_W, 3, register address width (2^ADDR_W = 8 registers)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back destination register
- wr_data  in  DATA_W  write-back data (selector output)
- flag_en  in  1  update Z/N from this write
- rx_addr  in  ADDR_W  operand X register
- ry_addr  in  ADDR_W  operand Y register
- rx_data  out  DATA_W  operand X value
- ry_data  out  DATA_W  operand Y value (also selector Ry input)
- rsv_en  in  1  reserve a destination for a pending bus load
- rsv_addr  in  ADDR_W  register being reserved
- stall  out  1  an operand register is pending
- zero  out  1  Z flag
- neg  out  1  N flag

## Operation
**Storage and reset**
- State: 8 registers × DATA_W, 8 pending bits, Z and N flipflops.
- rst high clears all registers, pending bits and flags to 0 immediately, independent of clk.
- While rst is high: rx_data = ry_data = 0, stall = 0, writes and reservations are ignored.

**Write**
- On rising clk with wr_en = 1, wr_data is stored in reg[wr_addr] and pending[wr_addr] is cleared.
- All 8 registers are writable; none is hardwired to 0.

**Read**
- rx_data is combinational.
- If wr_en = 1 and wr_addr == rx_addr, rx_data = wr_data (write-first bypass). Otherwise rx_data = reg[rx_addr].
- ry_data behaves identically using ry_addr.

**Reservation**
- On rising clk with rsv_en = 1, pending[rsv_addr] is set.
- Reserving an already-pending register leaves it set; this is not an error.
- rsv_en and wr_en to the same address in the same cycle: data is written and pending ends set (the new reservation wins).
- rsv_en and wr_en to different addresses in the same cycle: both take effect.

**Stall**
- stall = (pending[rx_addr] and not bypass_x) or (pending[ry_addr] and not bypass_y).
- bypass_x/y = wr_en and wr_addr matches the corresponding read address.
- A load completing this cycle therefore releases its consumer in the same cycle.
- stall is combinational from the addresses and registered pending state.

**Flags**
- On rising clk with wr_en = 1 and flag_en = 1: Z <= (wr_data == 0), N <= wr_data[DATA_W-1].
- flag_en without wr_en: flags hold.
- wr_en without flag_en: flags hold.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to readers via bypass.
- Reservation is visible on stall the cycle after rsv_en.
- Flags are visible the cycle after the write.
- No handshake beyond stall. The control unit holds its instruction while stall = 1.
- The reservation is released only by a write to the reserved register, or by rst.
- Reset deassertion is synchronous to clk at the system level. The first write is accepted on the first rising edge with rst low.

## Test plan
- Reset: write 0xA5 to r3, assert rst mid-cycle → rx_data for r3 reads 0x00 immediately; zero = 0, neg = 0, stall = 0 after release.
- Write/read and bypass: write 0x3C to r2, then hold wr_en to r2 with 0x81 while rx_addr = 2 → rx_data = 0x81 in the same cycle, and reads 0x81 next cycle.
- Flags: write 0x00 to r1 with flag_en → zero = 1, neg = 0 next cycle. Write 0x80 with flag_en → zero = 0, neg = 1. Write 0x00 without flag_en → flags unchanged.
- Scoreboard: rsv r5; next cycle ry_addr = 5 → stall = 1. Then write 0x44 to r5 → stall = 0 in that cycle and ry_data = 0x44; pending clear after the edge.
- Simultaneous reservation and write: rsv_en and wr_en both to r6 with 0x12 → r6 = 0x12 and stall = 1 when rx_addr = 6 on the following cycle.
- Independent ports: rsv r0 and write 0x7F to r7 in the same cycle → r7 = 0x7F; stall asserted for r0 reads only.

Source files
------------

// File: rtl/register_bank.sv
// General-purpose register file: one write port, two read ports with
// write-first bypass, a pending-load scoreboard driving stall, and Z/N flags.
module register_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_en,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [ADDR_W-1:0] ry_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] ry_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              stall,
    output logic              zero,
    output logic              neg
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic              bypass_x;
    logic              bypass_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // The reservation is applied after the write so it wins on an address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_en) begin
                pending[wr_addr] <= 1'b0;
            end
            if (rsv_en) begin
                pending[rsv_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (wr_en && flag_en) begin
            zero <= (wr_data == '0);
            neg  <= wr_data[DATA_W-1];
        end
    end

    // Reset gating keeps the bypass path from leaking wr_data while rst is high.
    always_comb begin
        bypass_x = wr_en && (wr_addr == rx_addr);
        bypass_y = wr_en && (wr_addr == ry_addr);
        rx_data  = '0;
        ry_data  = '0;
        stall    = 1'b0;
        if (!rst) begin
            rx_data = bypass_x ? wr_data : regs[rx_addr];
            ry_data = bypass_y ? wr_data : regs[ry_addr];
            stall   = (pending[rx_addr] && !bypass_x) ||
                      (pending[ry_addr] && !bypass_y);
        end
    end

endmodule
